// File: rtl/clock_chain_ctrl_if.sv
// Control inputs and status/pulse outputs of the HH:MM:SS digit-chain sequencer.
interface clock_chain_ctrl_if;
  logic        RUN;
  logic        SET_MODE;
  logic        SEL_NEXT;
  logic        INC;
  logic        TICK;
  logic [5:0]  ADV;
  logic [5:0]  DRST;
  logic [2:0]  FIELD;
  logic [1:0]  STATE;
  logic [23:0] TIME_BCD;

  modport slave (
    input  RUN, SET_MODE, SEL_NEXT, INC,
    output TICK, ADV, DRST, FIELD, STATE, TIME_BCD
  );

  modport master (
    output RUN, SET_MODE, SEL_NEXT, INC,
    input  TICK, ADV, DRST, FIELD, STATE, TIME_BCD
  );
endinterface

// File: rtl/clock_chain_ctrl.sv
// Sequencer for six one-hot digit counters forming HH:MM:SS: 1 Hz prescaler, per-digit
// advance/reset pulses, set mode, and a BCD mirror of the counters.
module clock_chain_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic               CLK,
  input logic               RESET,
  clock_chain_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TermCnt = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle = 2'b00, StCount = 2'b01, StSet = 2'b10} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_q, time_d;
  logic [2:0]    field_q, field_d;
  logic          tick_q, tick_d;
  logic [5:0]    adv_q, adv_d;
  logic [5:0]    drst_q, drst_d;
  logic          sel_q, inc_q;

  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic       sec_max, min_max, hour_23, inc_rise, sel_rise;

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] mx);
    return (d == mx) ? 4'd0 : d + 4'd1;
  endfunction

  assign d0 = time_q[3:0];
  assign d1 = time_q[7:4];
  assign d2 = time_q[11:8];
  assign d3 = time_q[15:12];
  assign d4 = time_q[19:16];
  assign d5 = time_q[23:20];

  assign sec_max  = (d0 == 4'd9) && (d1 == 4'd5);
  assign min_max  = sec_max && (d2 == 4'd9) && (d3 == 4'd5);
  assign hour_23  = (d5 == 4'd2) && (d4 == 4'd3);
  assign inc_rise = bus.INC & ~inc_q;
  assign sel_rise = bus.SEL_NEXT & ~sel_q;

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    time_d  = time_q;
    field_d = field_q;
    tick_d  = 1'b0;
    adv_d   = '0;
    drst_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.SET_MODE)  state_d = StSet;
        else if (bus.RUN)  state_d = StCount;
      end
      StCount: begin
        if (bus.SET_MODE)  state_d = StSet;
        else if (!bus.RUN) state_d = StIdle;
      end
      StSet: begin
        if (!bus.SET_MODE) state_d = bus.RUN ? StCount : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      // Seconds counters are cleared on the way into set mode.
      if (state_d == StSet) begin
        drst_d[1:0] = 2'b11;
        time_d[7:0] = '0;
      end
    end else if (state_q == StCount) begin
      if (presc_q == TermCnt) begin
        tick_d          = 1'b1;
        adv_d[0]        = 1'b1;
        time_d[3:0]     = wrap_inc(d0, 4'd9);
        if (d0 == 4'd9) begin
          adv_d[1]      = 1'b1;
          time_d[7:4]   = wrap_inc(d1, 4'd5);
        end
        if (sec_max) begin
          adv_d[2]      = 1'b1;
          time_d[11:8]  = wrap_inc(d2, 4'd9);
        end
        if (sec_max && (d2 == 4'd9)) begin
          adv_d[3]      = 1'b1;
          time_d[15:12] = wrap_inc(d3, 4'd5);
        end
        if (min_max) begin
          if (hour_23) begin
            drst_d[5:4]    = 2'b11;
            time_d[23:16]  = '0;
          end else begin
            adv_d[4]       = 1'b1;
            time_d[19:16]  = wrap_inc(d4, 4'd9);
            if (d4 == 4'd9) begin
              adv_d[5]      = 1'b1;
              time_d[23:20] = d5 + 4'd1;
            end
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (state_q == StSet) begin
      if (inc_rise) begin
        unique case (field_q)
          3'b001: begin
            adv_d[0]    = 1'b1;
            time_d[3:0] = wrap_inc(d0, 4'd9);
            if (d0 == 4'd9) begin
              adv_d[1]    = 1'b1;
              time_d[7:4] = wrap_inc(d1, 4'd5);
            end
          end
          3'b010: begin
            adv_d[2]     = 1'b1;
            time_d[11:8] = wrap_inc(d2, 4'd9);
            if (d2 == 4'd9) begin
              adv_d[3]      = 1'b1;
              time_d[15:12] = wrap_inc(d3, 4'd5);
            end
          end
          3'b100: begin
            if (hour_23) begin
              drst_d[5:4]   = 2'b11;
              time_d[23:16] = '0;
            end else begin
              adv_d[4]      = 1'b1;
              time_d[19:16] = wrap_inc(d4, 4'd9);
              if (d4 == 4'd9) begin
                adv_d[5]      = 1'b1;
                time_d[23:20] = d5 + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (sel_rise) field_d = {field_q[1:0], field_q[2]};
    end

    adv_d = adv_d & ~drst_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      presc_q <= '0;
      time_q  <= '0;
      field_q <= 3'b001;
      tick_q  <= 1'b0;
      adv_q   <= '0;
      drst_q  <= '0;
      sel_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      field_q <= field_d;
      tick_q  <= tick_d;
      adv_q   <= adv_d;
      drst_q  <= drst_d;
      sel_q   <= bus.SEL_NEXT;
      inc_q   <= bus.INC;
    end
  end

  assign bus.TICK     = tick_q;
  assign bus.ADV      = adv_q;
  assign bus.DRST     = drst_q;
  assign bus.FIELD    = field_q;
  assign bus.STATE    = state_q;
  assign bus.TIME_BCD = time_q;
endmodule

// File: tb/tb_clock_chain_ctrl.sv
// Scoreboard bench for clock_chain_ctrl: a seconds-of-day model predicts every pulse cycle.
module tb_clock_chain_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   model_sec = 0;
  int   bfield = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp, mon_got;

  clock_chain_ctrl_if bus();

  clock_chain_ctrl #(.TICK_DIV(4)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int sec);
    int h = sec / 3600;
    int m = (sec / 60) % 60;
    int s = sec % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected pulse cycle: every digit that changes gets ADV, except an hour 23->00 wrap.
  task automatic push_step(input logic t, input int new_sec);
    logic [23:0] ob, nb;
    logic [5:0]  adv, drst;
    ob = to_bcd(model_sec);
    nb = to_bcd(new_sec);
    for (int k = 0; k < 6; k++) adv[k] = (ob[4*k +: 4] != nb[4*k +: 4]);
    drst = '0;
    if (model_sec / 3600 == 23 && new_sec / 3600 == 0) begin
      drst      = 6'b110000;
      adv[5:4]  = 2'b00;
    end
    exp_q.push_back({t, adv, drst, nb});
    model_sec = new_sec;
  endtask

  task automatic push_inc();
    int h = model_sec / 3600;
    int m = (model_sec / 60) % 60;
    int s = model_sec % 60;
    case (bfield)
      0:       s = (s + 1) % 60;
      1:       m = (m + 1) % 60;
      default: h = (h + 1) % 24;
    endcase
    push_step(1'b0, h * 3600 + m * 60 + s);
  endtask

  task automatic pulse_inc();
    bus.INC = 1'b1;
    push_inc();
    @(negedge clk);
    bus.INC = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_sel();
    bus.SEL_NEXT = 1'b1;
    @(negedge clk);
    bus.SEL_NEXT = 1'b0;
    @(negedge clk);
    bfield = (bfield + 1) % 3;
  endtask

  task automatic enter_set();
    bus.SET_MODE = 1'b1;
    model_sec = model_sec - (model_sec % 60);
    exp_q.push_back({1'b0, 6'b000000, 6'b000011, to_bcd(model_sec)});
    @(negedge clk);
    check("state_set", {22'd0, bus.STATE}, 24'd2);
  endtask

  task automatic exit_set();
    bus.SET_MODE = 1'b0;
    @(negedge clk);
    check("state_idle_after_set", {22'd0, bus.STATE}, 24'd0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int ord[3] = '{2, 0, 1};
    int tgt[3];
    int cur, n;
    tgt[0] = s;
    tgt[1] = m;
    tgt[2] = h;
    enter_set();
    for (int i = 0; i < 3; i++) begin
      while (bfield != ord[i]) pulse_sel();
      cur = (ord[i] == 0) ? model_sec % 60 :
            (ord[i] == 1) ? (model_sec / 60) % 60 : model_sec / 3600;
      n = (ord[i] == 2) ? (tgt[ord[i]] - cur + 24) % 24 : (tgt[ord[i]] - cur + 60) % 60;
      repeat (n) pulse_inc();
    end
    check("preload_bcd", bus.TIME_BCD, to_bcd(h * 3600 + m * 60 + s));
    exit_set();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) push_step(1'b1, (model_sec + 1) % 86400);
    bus.RUN = 1'b1;
    repeat (4 * n + 1) @(negedge clk);
    bus.RUN = 1'b0;
    @(negedge clk);
    check("state_idle_after_run", {22'd0, bus.STATE}, 24'd0);
  endtask

  // Monitor: any pulse cycle must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && (bus.TICK || bus.ADV != 6'd0 || bus.DRST != 6'd0)) begin
      tests++;
      if ((bus.ADV & bus.DRST) != 6'd0) begin
        fails++;
        $display("FAIL adv_drst_overlap: adv %b drst %b required disjoint", bus.ADV, bus.DRST);
      end
      mon_got = {bus.TICK, bus.ADV, bus.DRST, bus.TIME_BCD};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got tick %b adv %b drst %b time %h, none expected",
                 bus.TICK, bus.ADV, bus.DRST, bus.TIME_BCD);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL pulse_cycle: got tick %b adv %b drst %b time %h, expected tick %b adv %b drst %b time %h",
                   mon_got[36], mon_got[35:30], mon_got[29:24], mon_got[23:0],
                   mon_exp[36], mon_exp[35:30], mon_exp[29:24], mon_exp[23:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_tick, second_tick, h;
    rst = 1'b1;
    bus.RUN = 1'b0;
    bus.SET_MODE = 1'b0;
    bus.SEL_NEXT = 1'b0;
    bus.INC = 1'b0;
    #3;
    check("rst_state", {22'd0, bus.STATE}, 24'd0);
    check("rst_time", bus.TIME_BCD, 24'd0);
    check("rst_field", {21'd0, bus.FIELD}, 24'd1);
    check("rst_pulses", {11'd0, bus.TICK, bus.ADV, bus.DRST}, 24'd0);
    @(negedge clk);
    rst = 1'b0;

    // First tick latency and period.
    push_step(1'b1, 1);
    push_step(1'b1, 2);
    first_tick = 0;
    second_tick = 0;
    bus.RUN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.TICK) begin
        if (first_tick == 0) first_tick = i;
        else if (second_tick == 0) second_tick = i;
      end
    end
    check("first_tick_latency", 24'(first_tick), 24'd5);
    check("tick_period", 24'(second_tick - first_tick), 24'd4);
    @(negedge clk);
    bus.RUN = 1'b0;
    @(negedge clk);

    // Directed boundary preloads.
    set_time(0, 0, 59);
    run_ticks(1);
    set_time(23, 59, 59);
    run_ticks(2);
    set_time(9, 59, 59);
    run_ticks(1);
    set_time(19, 59, 58);
    run_ticks(2);

    // Randomized preloads near carry boundaries.
    repeat (4) begin
      h = $urandom_range(0, 23);
      set_time(h, ($urandom_range(0, 1) != 0) ? 59 : $urandom_range(0, 59),
               $urandom_range(56, 59));
      run_ticks($urandom_range(1, 4));
    end

    // Held INC at hours 23 acts once; then simultaneous SEL_NEXT/INC on seconds.
    enter_set();
    while (bfield != 2) pulse_sel();
    h = model_sec / 3600;
    repeat ((23 - h + 24) % 24) pulse_inc();
    bus.INC = 1'b1;
    push_inc();
    repeat (10) @(negedge clk);
    bus.INC = 1'b0;
    @(negedge clk);
    check("held_inc_hours", {16'd0, bus.TIME_BCD[23:16]}, 24'd0);
    pulse_sel();
    check("field_secs", {21'd0, bus.FIELD}, 24'd1);
    bus.SEL_NEXT = 1'b1;
    bus.INC = 1'b1;
    push_inc();
    @(negedge clk);
    bus.SEL_NEXT = 1'b0;
    bus.INC = 1'b0;
    @(negedge clk);
    bfield = 1;
    check("simul_field", {21'd0, bus.FIELD}, 24'd2);
    check("simul_secs", {16'd0, bus.TIME_BCD[7:0]}, 24'h000001);
    exit_set();
    check("field_retained", {21'd0, bus.FIELD}, 24'd2);

    // Asynchronous reset while a tick pulse is on the outputs.
    push_step(1'b1, (model_sec + 1) % 86400);
    bus.RUN = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_tick", {23'd0, bus.TICK}, 24'd1);
    rst = 1'b1;
    #1;
    check("async_rst_pulses", {11'd0, bus.TICK, bus.ADV, bus.DRST}, 24'd0);
    check("async_rst_state", {22'd0, bus.STATE}, 24'd0);
    check("async_rst_time", bus.TIME_BCD, 24'd0);
    check("async_rst_field", {21'd0, bus.FIELD}, 24'd1);
    @(negedge clk);
    bus.RUN = 1'b0;
    rst = 1'b0;
    model_sec = 0;
    bfield = 0;
    repeat (3) @(negedge clk);
    check("queue_drained", 24'(exp_q.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
